pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

- Parametrised, pipelined successor to the 8-bit combinational bidirectional barrel shifter.
- Shifts a WIDTH-bit word left or right by 0..WIDTH-1 positions in logical, arithmetic or rotate mode.
- Uses one registered stage per shift-amount bit, with valid/ready handshakes on both sides.
- Sits between an operand source (e.g. ALU operand latch) and a result consumer; sustains one operation per cycle.

## Interface

Parameters:
- WIDTH, 8, data width; power of two, ≥ 2.
- SHW, $clog2(WIDTH), shift-amount width. Derived; never overridden.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- in_valid, input, 1, input operation present.
- in_ready, output, 1, shifter can accept this cycle.
- in_data, input, WIDTH, operand.
- shamt, input, SHW, shift amount.
- dir, input, 1, direction: 0 = right, 1 = left.
- mode, input, 2, shift mode:
  - 00 logical.
  - 01 arithmetic.
  - 10 rotate.
  - 11 reserved, executes as logical.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts the result.
- out_data, output, WIDTH, shifted result.
- out_sticky, output, 1, OR of shifted-out bits. Present only with BSHIFT_STICKY_EN.

## Operation

- **Acceptance:** an operation is accepted when in_valid && in_ready. in_data, shamt, dir and mode are captured together and travel down the pipeline with the operation. Input changes after acceptance have no effect.
- **Stage order:** SHW stages, stage 0 to stage SHW-1.
  - Stage k conditionally shifts by 2^(SHW-1-k) when shamt bit SHW-1-k is 1, largest step first.
  - Each stage registers its data, valid, the remaining shamt bits, dir, mode and (if enabled) sticky.
- **Logical:** vacated positions are filled with 0.
- **Arithmetic:**
  - dir=0: vacated MSBs are filled with the original bit WIDTH-1 (sign of the accepted operand, carried through stages).
  - dir=1: identical to logical left.
- **Rotate:** bits leaving one end re-enter at the other; no bits are lost.
- **shamt=0:** out_data = in_data for every mode/dir.
- **Flow control** (per stage i, capacity one operation):
  - The stage loads when !valid_i || ready_i.
  - ready_i = !valid_{i+1} || ready_{i+1}, with ready_{SHW-1} = out_ready.
  - in_ready = !valid_0 || ready_0.
- **Bubbles:** bubbles collapse. A stalled output does not block upstream stages that still hold empty slots.
- **Ordering:** results leave in acceptance order; no reordering, no drops, no duplication.
- **Output hold:** while out_valid && !out_ready, out_data (and out_sticky) are held stable.

## Timing

- **Reset** (rst_n low, asynchronous):
  - All stage valids = 0, all stage data = 0.
  - out_valid = 0, out_data = 0, out_sticky = 0.
  - in_ready = 1 from the first cycle after rst_n deasserts.
- **Reset mid-operation:** all in-flight operations are discarded; none appear after reset release.
- **Latency:** SHW cycles from the acceptance edge to out_valid = 1 with an unstalled output; WIDTH=8 gives 3 cycles.
- **Throughput:** one operation per cycle when out_ready stays high.
- **Full pipeline:** holds at most SHW operations. When all stages are valid and out_ready = 0, in_ready = 0.
- **Simultaneous accept and drain:** with a full pipeline and out_ready = 1 in the same cycle, in_ready = 1 and the new operation is accepted. in_ready is combinational from out_ready through the ready chain.
- in_valid dropping while in_ready = 0 is permitted; nothing is captured.

## Configuration

- **BSHIFT_STICKY_EN defined:**
  - out_sticky port exists; each stage ORs every bit it discards into a registered sticky bit, cleared at acceptance.
  - Rotate mode always gives sticky = 0.
  - Left shifts collect bits leaving the MSB end; right shifts (logical or arithmetic) collect bits leaving the LSB end.
- **BSHIFT_STICKY_EN undefined:** out_sticky port and all sticky logic are absent; all other behaviour is identical.

## Test plan

All scenarios use WIDTH=8.

- **Reset:** assert rst_n=0 mid-stream with 3 operations in flight, release → out_valid=0, out_data=0x00, in_ready=1, no stale result emerges.
- **Mode/direction sweep,** in_data=0xB4, shamt=3:
  - logical right → 0x16; logical left → 0xA0.
  - arithmetic right → 0xF6; arithmetic left → 0xA0.
  - rotate right → 0x96; rotate left → 0xA5.
  - mode=11 right → 0x16.
  - Each result appears exactly 3 cycles after acceptance.
- **Passthrough:** shamt=0 for all modes/dirs with in_data=0x5A → 0x5A; shamt=7 logical right of 0x80 → 0x01.
- **Backpressure:** out_ready=0, offer 4 back-to-back operations → first 3 accepted, in_ready=0 on the 4th. While stalled, out_data holds the first result. Raise out_ready → 4th accepted the same cycle; results emerge in order, one per cycle.
- **Throughput:** 100 random operations, out_ready=1, in_valid=1 → 100 results in 102 cycles after the first, all matching the reference model.
- **Sticky (BSHIFT_STICKY_EN):**
  - logical right 0xB4 by 3 → sticky=1; logical right 0xB0 by 3 → sticky=0.
  - left 0x1F by 3 → sticky=0; left 0x20 by 3 → sticky=1.
  - rotate 0xFF by 5 → sticky=0.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: WIDTH-bit logical/arithmetic/rotate shifter.
// It has one registered stage per shift-amount bit, and the largest step comes first.
// Valid/ready handshakes are used on both sides, and bubbles collapse.
// Optional feature macro: BSHIFT_STICKY_EN adds out_sticky, which is the OR of all discarded bits.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSHIFT_STICKY_EN
  ,
  output logic             out_sticky
`endif
);

  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  // Shift d by s positions. An arithmetic right shift keeps the MSB.
  // So the MSB of any stage input is still the sign of the accepted operand.
  function automatic logic [WIDTH-1:0] step_shift(input logic [WIDTH-1:0] d, input int s,
                                                  input logic left, input logic [1:0] m);
    logic [2*WIDTH-1:0] dd;
    logic [WIDTH-1:0]   r;
    dd = {d, d};
    if (m == MODE_ROT) begin
      if (left) r = dd[2*WIDTH-1-s -: WIDTH];
      else      r = dd[s +: WIDTH];
    end else if (left) begin
      r = d << s;
    end else if (m == MODE_ARITH) begin
      r = WIDTH'($signed(d) >>> s);
    end else begin
      r = d >> s;
    end
    return r;
  endfunction

`ifdef BSHIFT_STICKY_EN
  // Return 1 when a shift of d by s drops any 1 bit. A rotate never drops bits.
  function automatic logic step_lost(input logic [WIDTH-1:0] d, input int s,
                                     input logic left, input logic [1:0] m);
    logic [WIDTH-1:0] lost;
    if (m == MODE_ROT) lost = '0;
    else if (left)     lost = d >> (WIDTH - s);
    else               lost = d << (WIDTH - s);
    return |lost;
  endfunction
`endif

  logic [SHW-1:0] valid_s;
  logic [SHW-1:0] ready_s;

  // Backward ready chain: a stage may hand off if the next stage is empty or draining.
  always_comb begin
    logic nxt;
    nxt = out_ready;
    for (int i = SHW - 1; i >= 0; i--) begin
      ready_s[i] = nxt;
      nxt        = !valid_s[i] || nxt;
    end
  end

  assign in_ready = !valid_s[0] || ready_s[0];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int STEP = 1 << (SHW - 1 - k);

    logic [WIDTH-1:0] src_data_s;
    logic             src_valid_s;
    logic             src_dir_s;
    logic [1:0]       src_mode_s;
    logic             src_bit_s;
    logic             load_s;
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    if (k == 0) begin : g_src
      assign src_data_s  = in_data;
      assign src_valid_s = in_valid;
      assign src_dir_s   = dir;
      assign src_mode_s  = mode;
      assign src_bit_s   = shamt[SHW-1];
    end else begin : g_src
      assign src_data_s  = g_stage[k-1].data_q;
      assign src_valid_s = g_stage[k-1].valid_q;
      assign src_dir_s   = g_stage[k-1].g_fwd.dir_q;
      assign src_mode_s  = g_stage[k-1].g_fwd.mode_q;
      assign src_bit_s   = g_stage[k-1].g_fwd.rem_q[SHW-1-k];
    end

    assign load_s     = !valid_q || ready_s[k];
    assign valid_s[k] = valid_q;

    // Take the upstream operation when allowed, shifting it if its bit is set; otherwise hold.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_s) begin
        valid_d = src_valid_s;
        if (src_valid_s) begin
          if (src_bit_s) data_d = step_shift(src_data_s, STEP, src_dir_s, src_mode_s);
          else           data_d = src_data_s;
        end else begin
          data_d = data_q;
        end
      end else begin
        valid_d = valid_q;
      end
    end

    // Stage data/valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    // The final stage needs no control fields. Earlier stages carry dir, mode and the
    // shift-amount bits that are still unused.
    if (k < SHW - 1) begin : g_fwd
      logic             dir_d, dir_q;
      logic [1:0]       mode_d, mode_q;
      logic [SHW-2-k:0] src_rem_s, rem_d, rem_q;

      if (k == 0) begin : g_rsrc
        assign src_rem_s = shamt[SHW-2:0];
      end else begin : g_rsrc
        assign src_rem_s = g_stage[k-1].g_fwd.rem_q[SHW-2-k:0];
      end

      // Control fields follow their operation into this stage.
      always_comb begin
        if (load_s && src_valid_s) begin
          dir_d  = src_dir_s;
          mode_d = src_mode_s;
          rem_d  = src_rem_s;
        end else begin
          dir_d  = dir_q;
          mode_d = mode_q;
          rem_d  = rem_q;
        end
      end

      // Control field registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dir_q  <= 1'b0;
          mode_q <= 2'b00;
          rem_q  <= '0;
        end else begin
          dir_q  <= dir_d;
          mode_q <= mode_d;
          rem_q  <= rem_d;
        end
      end
    end

`ifdef BSHIFT_STICKY_EN
    logic src_sticky_s, sticky_d, sticky_q;

    if (k == 0) begin : g_ssrc
      assign src_sticky_s = 1'b0;
    end else begin : g_ssrc
      assign src_sticky_s = g_stage[k-1].sticky_q;
    end

    // Accumulate the bits discarded by this stage. The sticky bit starts at 0 on acceptance.
    always_comb begin
      if (load_s && src_valid_s) begin
        if (src_bit_s) sticky_d = src_sticky_s | step_lost(src_data_s, STEP, src_dir_s, src_mode_s);
        else           sticky_d = src_sticky_s;
      end else begin
        sticky_d = sticky_q;
      end
    end

    // Sticky register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_q <= 1'b0;
      else        sticky_q <= sticky_d;
    end
`endif
  end

  assign out_valid = g_stage[SHW-1].valid_q;
  assign out_data  = g_stage[SHW-1].data_q;
`ifdef BSHIFT_STICKY_EN
  assign out_sticky = g_stage[SHW-1].sticky_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8).
// A bit-at-a-time reference model and scoreboard are checked on every cycle,
// and directed vectors carry literal expectations.
`timescale 1ns/1ps
module tb_pipelined_barrel_shifter;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, dir, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] shamt;
  logic [1:0] mode;
`ifdef BSHIFT_STICKY_EN
  logic       out_sticky;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [8:0] exp_q[$];
  int         acc_q[$];
  logic [7:0] last_data;
  logic       last_sticky;
  int         last_lat, last_out_cyc;
  int         n_out = 0;

  pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shamt(shamt), .dir(dir), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BSHIFT_STICKY_EN
    , .out_sticky(out_sticky)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: shift one position at a time. Return {sticky, data}.
  function automatic logic [8:0] model(input logic [7:0] d, input int s, input logic left,
                                       input logic [1:0] m);
    logic [7:0] r;
    logic       st;
    r  = d;
    st = 1'b0;
    for (int i = 0; i < s; i++) begin
      if (m == 2'b10) begin
        r = left ? {r[6:0], r[7]} : {r[0], r[7:1]};
      end else if (left) begin
        st = st | r[7];
        r  = {r[6:0], 1'b0};
      end else begin
        st = st | r[0];
        r  = {(m == 2'b01) ? d[7] : 1'b0, r[7:1]};
      end
    end
    return {st, r};
  endfunction

  // Scoreboard: check the output against the oldest expectation, then record acceptances.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0][7:0]});
`ifdef BSHIFT_STICKY_EN
          chk("out_sticky", {31'd0, out_sticky}, {31'd0, exp_q[0][8]});
          if (out_ready) last_sticky = out_sticky;
`endif
          if (out_ready) begin
            last_data    = out_data;
            last_lat     = cyc - acc_q[0];
            last_out_cyc = cyc;
            n_out++;
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, int'(shamt), dir, mode));
        acc_q.push_back(cyc);
      end
    end
  end

  // Present one operation and keep it until accepted. Call and return at posedge+1.
  task automatic offer(input logic [7:0] d, input logic [2:0] s, input logic dr, input logic [1:0] m);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    shamt    = s;
    dir      = dr;
    mode     = m;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  logic [1:0] sw_mode [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
  logic       sw_dir  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] sw_exp  [7] = '{8'h16, 8'hA0, 8'hF6, 8'hA0, 8'h96, 8'hA5, 8'h16};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  initial begin
    logic [8:0] mres;
    logic [7:0] exp_a;
    int         n0, c_first, r_cyc;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; shamt = 3'd0; dir = 1'b0;
    mode = 2'b00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Mode/direction sweep on 0xB4 by 3.
    for (int i = 0; i < 7; i++) begin
      mres = model(8'hB4, 3, sw_dir[i], sw_mode[i]);
      chk("model_pin_sweep", {24'd0, mres[7:0]}, {24'd0, sw_exp[i]});
      offer(8'hB4, 3'd3, sw_dir[i], sw_mode[i]);
      drain();
      chk("sweep_data", {24'd0, last_data}, {24'd0, sw_exp[i]});
      chk("sweep_latency", last_lat, 32'd3);
    end

    // Passthrough with shamt=0, then a full-range shift.
    for (int m = 0; m < 4; m++) begin
      for (int d = 0; d < 2; d++) begin
        offer(8'h5A, 3'd0, d[0], m[1:0]);
        drain();
        chk("pass_data", {24'd0, last_data}, 32'h5A);
      end
    end
    offer(8'h80, 3'd7, 1'b0, 2'b00);
    drain();
    chk("shr7_data", {24'd0, last_data}, 32'h01);

`ifdef BSHIFT_STICKY_EN
    offer(8'hB4, 3'd3, 1'b0, 2'b00); drain(); chk("sticky_b4_r3", {31'd0, last_sticky}, 32'd1);
    offer(8'hB0, 3'd3, 1'b0, 2'b00); drain(); chk("sticky_b0_r3", {31'd0, last_sticky}, 32'd0);
    offer(8'h1F, 3'd3, 1'b1, 2'b00); drain(); chk("sticky_1f_l3", {31'd0, last_sticky}, 32'd0);
    offer(8'h20, 3'd3, 1'b1, 2'b00); drain(); chk("sticky_20_l3", {31'd0, last_sticky}, 32'd1);
    offer(8'hFF, 3'd5, 1'b0, 2'b10); drain(); chk("sticky_rot", {31'd0, last_sticky}, 32'd0);
`endif

    // Backpressure: three operations fill the pipe, and the fourth waits until drain.
    n0 = n_out;
    out_ready = 1'b0;
    mres  = model(8'h81, 1, 1'b0, 2'b01);
    exp_a = mres[7:0];
    chk("model_pin_asr", {24'd0, exp_a}, 32'hC0);
    offer(8'h81, 3'd1, 1'b0, 2'b01);
    offer(8'h3C, 3'd2, 1'b1, 2'b10);
    offer(8'hF0, 3'd4, 1'b0, 2'b00);
    in_valid = 1'b1; in_data = 8'h77; shamt = 3'd6; dir = 1'b1; mode = 2'b00;
    @(negedge clk);
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (2) @(negedge clk);
    chk("bp_hold_first", {24'd0, out_data}, {24'd0, exp_a});
    chk("bp_in_ready_still", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    r_cyc = cyc;
    chk("bp_accept_on_drain", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("bp_count", n_out - n0, 32'd4);
    chk("bp_drain_span", last_out_cyc - r_cyc, 32'd3);

    // Throughput: 100 random operations, back to back.
    n0      = n_out;
    c_first = cyc;
    for (int i = 0; i < 100; i++) begin
      offer(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)));
    end
    drain();
    chk("tput_count", n_out - n0, 32'd100);
    chk("tput_span", last_out_cyc - c_first, 32'd102);

    // Reset with three operations in flight.
    n0 = n_out;
    out_ready = 1'b0;
    offer(8'h11, 3'd1, 1'b0, 2'b00);
    offer(8'h22, 3'd2, 1'b1, 2'b00);
    offer(8'h33, 3'd3, 1'b0, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid_async", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", {24'd0, out_data}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_stale", n_out - n0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
